// File: rtl/ctrl_entrada.sv
// rtl/ctrl_entrada.sv - input-request controller: debounced switches and USART word
//
// Purpose: serves processor input requests from either the board switches
// (debounced enter key) or a 32-bit little-endian word assembled from USART
// bytes, arbitrating between the two and returning each word with a one-cycle ack.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   reqTeclado          level request for a switch word (held until ack)
//   reqUsart            level request for a USART word (held until ack)
//   chave               enter pushbutton, already synchronized
//   chaves[31:0]        switch value
//   dadoPronto          one-cycle strobe, byteUsart valid
//   byteUsart[7:0]      received USART byte
//   dadosIN[31:0]       returned word, valid with ack, held until next ack
//   ack                 one-cycle acknowledge
//   fonte               source of last ack (0 switches, 1 USART)
//   ocupado             FSM not idle
//   overrun             sticky: a USART byte was dropped
//   estado[2:0]         FSM state for LEDs
module ctrl_entrada #(
    parameter int DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqTeclado,
    input  logic        reqUsart,
    input  logic        chave,
    input  logic [31:0] chaves,
    input  logic        dadoPronto,
    input  logic [7:0]  byteUsart,
    output logic [31:0] dadosIN,
    output logic        ack,
    output logic        fonte,
    output logic        ocupado,
    output logic        overrun,
    output logic [2:0]  estado
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ESPERA_TECLA = 3'd1,
        ESPERA_USART = 3'd2,
        CONCLUI      = 3'd3
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        armado_q;
    logic [31:0] word_q;
    logic [2:0]  count_q;
    logic        overrun_q;
    logic [31:0] dados_q, dados_d;
    logic        ack_q, ack_d;
    logic        fonte_q, fonte_d;
    logic        ultimo_q, ultimo_d;
    logic        tecla;
    logic        consume;
    logic        clr_armado;
    logic        word_full;

    assign tecla     = (cnt_q == CNT_MAX) && armado_q;
    assign word_full = (count_q == 3'd4);

    // Debouncer: counts saturating while pressed; a release re-arms the key,
    // and a granted key press disarms it so a held key yields only one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            armado_q <= 1'b0;
        end else if (!chave) begin
            cnt_q    <= '0;
            armado_q <= 1'b1;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (clr_armado) begin
                armado_q <= 1'b0;
            end
        end
    end

    // USART assembler. On a simultaneous consume and strobe the new byte
    // starts the next word instead of being dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else if (consume) begin
            if (dadoPronto) begin
                word_q[7:0] <= byteUsart;
                count_q     <= 3'd1;
            end else begin
                count_q     <= 3'd0;
            end
        end else if (dadoPronto) begin
            if (word_full) begin
                overrun_q <= 1'b1;
            end else begin
                word_q[{count_q[1:0], 3'b000} +: 8] <= byteUsart;
                count_q <= count_q + 3'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. With both requests pending the source that was not
    // served last wins, giving alternation under contention.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (reqTeclado && (!reqUsart || ultimo_q)) begin
                    state_d = ESPERA_TECLA;
                end else if (reqUsart) begin
                    state_d = ESPERA_USART;
                end
            end
            ESPERA_TECLA: begin
                if (!reqTeclado) begin
                    state_d = IDLE;
                end else if (tecla) begin
                    state_d = CONCLUI;
                end
            end
            ESPERA_USART: begin
                if (!reqUsart) begin
                    state_d = IDLE;
                end else if (word_full) begin
                    state_d = CONCLUI;
                end
            end
            CONCLUI: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered outputs plus side strobes
    always_comb begin
        dados_d    = dados_q;
        ack_d      = 1'b0;
        fonte_d    = fonte_q;
        ultimo_d   = ultimo_q;
        consume    = 1'b0;
        clr_armado = 1'b0;
        case (state_q)
            ESPERA_TECLA: begin
                if (reqTeclado && tecla) begin
                    dados_d    = chaves;
                    ack_d      = 1'b1;
                    fonte_d    = 1'b0;
                    ultimo_d   = 1'b0;
                    clr_armado = 1'b1;
                end
            end
            ESPERA_USART: begin
                if (reqUsart && word_full) begin
                    dados_d  = word_q;
                    ack_d    = 1'b1;
                    fonte_d  = 1'b1;
                    ultimo_d = 1'b1;
                    consume  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dados_q  <= '0;
            ack_q    <= 1'b0;
            fonte_q  <= 1'b0;
            ultimo_q <= 1'b1;
        end else begin
            dados_q  <= dados_d;
            ack_q    <= ack_d;
            fonte_q  <= fonte_d;
            ultimo_q <= ultimo_d;
        end
    end

    assign dadosIN = dados_q;
    assign ack     = ack_q;
    assign fonte   = fonte_q;
    assign overrun = overrun_q;
    assign estado  = state_q;
    assign ocupado = (state_q != IDLE);

endmodule

// File: tb/tb_ctrl_entrada.sv
// tb/tb_ctrl_entrada.sv - directed self-checking bench for ctrl_entrada
module tb_ctrl_entrada;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqTeclado;
    logic        reqUsart;
    logic        chave;
    logic [31:0] chaves;
    logic        dadoPronto;
    logic [7:0]  byteUsart;
    logic [31:0] dadosIN;
    logic        ack;
    logic        fonte;
    logic        ocupado;
    logic        overrun;
    logic [2:0]  estado;

    int total = 0;
    int bad   = 0;

    ctrl_entrada #(.DEBOUNCE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .reqTeclado (reqTeclado),
        .reqUsart   (reqUsart),
        .chave      (chave),
        .chaves     (chaves),
        .dadoPronto (dadoPronto),
        .byteUsart  (byteUsart),
        .dadosIN    (dadosIN),
        .ack        (ack),
        .fonte      (fonte),
        .ocupado    (ocupado),
        .overrun    (overrun),
        .estado     (estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        dadoPronto = 1'b1;
        byteUsart  = b;
        tick();
        dadoPronto = 1'b0;
    endtask

    // Returns the number of edges until ack is seen (max if it never is).
    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < max);
    endtask

    int n;
    int nack;

    initial begin
        rst = 1'b1; reqTeclado = 1'b0; reqUsart = 1'b0; chave = 1'b0;
        chaves = 32'h0; dadoPronto = 1'b0; byteUsart = 8'h0;

        // Reset with strobes pulsing
        dadoPronto = 1'b1; byteUsart = 8'h55;
        tick();
        byteUsart = 8'h66;
        tick();
        chk("rst_dados", dadosIN, 32'h0);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_overrun", {31'b0, overrun}, 32'h0);
        chk("rst_estado", {29'b0, estado}, 32'h0);
        chk("rst_ocupado", {31'b0, ocupado}, 32'h0);
        rst = 1'b0; dadoPronto = 1'b0;

        // USART assembly
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        reqUsart = 1'b1;
        tick();
        chk("us_ack_early", {31'b0, ack}, 32'h0);
        chk("us_estado", {29'b0, estado}, 32'd2);
        chk("us_ocupado", {31'b0, ocupado}, 32'h1);
        tick();
        chk("us_ack", {31'b0, ack}, 32'h1);
        chk("us_data", dadosIN, 32'h44332211);
        chk("us_fonte", {31'b0, fonte}, 32'h1);
        chk("us_concl", {29'b0, estado}, 32'd3);
        reqUsart = 1'b0;
        tick();
        chk("us_ack_width", {31'b0, ack}, 32'h0);
        chk("us_idle", {29'b0, estado}, 32'd0);
        chk("us_no_ovr", {31'b0, overrun}, 32'h0);

        // Debounce: short pulse gives nothing
        chaves = 32'hCAFE0001; reqTeclado = 1'b1;
        tick();
        nack = 0;
        chave = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); nack += int'(ack); end
        chave = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); nack += int'(ack); end
        chk("db_short_noack", nack, 0);
        chk("db_wait_state", {29'b0, estado}, 32'd1);

        // Full press: ack after DEBOUNCE+1 edges
        chave = 1'b1;
        wait_ack(12, n);
        chk("db_lat", n, 5);
        chk("db_data", dadosIN, 32'hCAFE0001);
        chk("db_fonte", {31'b0, fonte}, 32'h0);
        reqTeclado = 1'b0;
        tick();
        chk("db_ack_width", {31'b0, ack}, 32'h0);

        // Held key with new request: no ack until release plus full press
        reqTeclado = 1'b1;
        nack = 0;
        for (int i = 0; i < 6; i++) begin tick(); nack += int'(ack); end
        chk("db_held_noack", nack, 0);
        chk("db_held_state", {29'b0, estado}, 32'd1);
        chave = 1'b0;
        tick();
        chave = 1'b1; chaves = 32'h12345678;
        wait_ack(12, n);
        chk("db_rearm_lat", n, 5);
        chk("db_rearm_data", dadosIN, 32'h12345678);
        reqTeclado = 1'b0;
        tick();

        // Arbitration after reset
        rst = 1'b1; chave = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chave = 1'b1; chaves = 32'h0BADF00D;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        reqTeclado = 1'b1; reqUsart = 1'b1;
        tick();
        chk("arb_first_sw", {29'b0, estado}, 32'd1);
        tick();
        chk("arb_sw_ack", {31'b0, ack}, 32'h1);
        chk("arb_sw_fonte", {31'b0, fonte}, 32'h0);
        chk("arb_sw_data", dadosIN, 32'h0BADF00D);
        reqTeclado = 1'b0;
        tick();
        chk("arb_gap", {31'b0, ack}, 32'h0);
        reqTeclado = 1'b1;
        tick();
        chk("arb_second_us", {29'b0, estado}, 32'd2);
        tick();
        chk("arb_us_ack", {31'b0, ack}, 32'h1);
        chk("arb_us_fonte", {31'b0, fonte}, 32'h1);
        chk("arb_us_data", dadosIN, 32'hA4A3A2A1);
        reqUsart = 1'b0;
        tick();
        chave = 1'b0;
        tick();
        chave = 1'b1;
        wait_ack(12, n);
        chk("arb_third_lat", n, 5);
        chk("arb_third_fonte", {31'b0, fonte}, 32'h0);
        reqTeclado = 1'b0; chave = 1'b0;
        tick();

        // Overrun
        chk("ov_clear", {31'b0, overrun}, 32'h0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("ov_set", {31'b0, overrun}, 32'h1);
        reqUsart = 1'b1;
        tick();
        dadoPronto = 1'b1; byteUsart = 8'hAA;
        tick();
        dadoPronto = 1'b0;
        chk("ov_ack", {31'b0, ack}, 32'h1);
        chk("ov_data", dadosIN, 32'h04030201);
        reqUsart = 1'b0;
        tick();
        send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        reqUsart = 1'b1;
        wait_ack(8, n);
        chk("ov_next_lat", n, 2);
        chk("ov_next_data", dadosIN, 32'hDDCCBBAA);
        chk("ov_sticky", {31'b0, overrun}, 32'h1);
        reqUsart = 1'b0;
        tick();

        // Abort and reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_ovr_rst", {31'b0, overrun}, 32'h0);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        reqUsart = 1'b1;
        tick(); tick();
        chk("ab_waiting", {29'b0, estado}, 32'd2);
        reqUsart = 1'b0;
        tick();
        chk("ab_idle", {29'b0, estado}, 32'd0);
        chk("ab_noack", {31'b0, ack}, 32'h0);
        send_byte(8'h40);
        reqUsart = 1'b1;
        wait_ack(8, n);
        chk("ab_lat", n, 2);
        chk("ab_data", dadosIN, 32'h40302010);
        reqUsart = 1'b0;
        tick();

        send_byte(8'h77); send_byte(8'h88);
        reqUsart = 1'b1;
        tick();
        chk("rm_waiting", {29'b0, estado}, 32'd2);
        rst = 1'b1; reqUsart = 1'b0;
        tick();
        chk("rm_estado", {29'b0, estado}, 32'd0);
        chk("rm_ack", {31'b0, ack}, 32'h0);
        rst = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        reqUsart = 1'b1;
        wait_ack(8, n);
        chk("rm_lat", n, 2);
        chk("rm_data", dadosIN, 32'h04030201);
        chk("rm_no_ovr", {31'b0, overrun}, 32'h0);
        reqUsart = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
